// File: rtl/dwa_thermometer_driver.sv
// Sign-magnitude code to 14-element unit-element DAC drive with data-weighted averaging.
// Optional macro DWA_ROTATE_EN enables pointer rotation; without it the output is a static thermometer.
module dwa_thermometer_driver #(
  parameter  int CODE_W    = 4,
  localparam int N_ELEM    = 2 * ((1 << (CODE_W - 1)) - 1),
  localparam int MID_LEVEL = N_ELEM / 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [CODE_W-1:0] i_code_in,
  input  logic              i_in_valid,
  input  logic              i_mute,
  output logic [N_ELEM-1:0] o_elem_out,
  output logic              o_valid_out,
  output logic [3:0]        o_ptr_out
);

  logic              w_sign;
  logic [3:0]        w_mag;
  logic [3:0]        w_level;
  logic [N_ELEM:0]   w_therm_full;
  logic [N_ELEM-1:0] w_therm;
  logic [N_ELEM-1:0] w_elem;

  logic [N_ELEM-1:0] r_elem;
  logic              r_valid;
  logic [3:0]        r_level;

  assign w_sign = i_code_in[CODE_W-1];
  assign w_mag  = {1'b0, i_code_in[CODE_W-2:0]};

  // Negative zero naturally lands on mid-scale because 7 - 0 == 7 + 0.
  always_comb begin
    w_level = 4'(MID_LEVEL);
    if (i_mute)
      w_level = 4'(MID_LEVEL);
    else if (w_sign)
      w_level = 4'(MID_LEVEL) - w_mag;
    else
      w_level = 4'(MID_LEVEL) + w_mag;
  end

  // One extra bit so that L == N_ELEM yields all ones without overflow.
  assign w_therm_full = ({{N_ELEM{1'b0}}, 1'b1} << w_level) - {{N_ELEM{1'b0}}, 1'b1};
  assign w_therm      = w_therm_full[N_ELEM-1:0];

`ifdef DWA_ROTATE_EN
  logic [3:0]          r_ptr;
  logic [4:0]          w_ptr_sum;
  logic [3:0]          w_ptr_next;
  logic [2*N_ELEM-1:0] w_rot;

  // Rotate-left by ptr: the upper half of the shifted doubled word wraps high bits into low indices.
  assign w_rot      = {w_therm, w_therm} << r_ptr;
  assign w_elem     = w_rot[2*N_ELEM-1:N_ELEM];
  assign w_ptr_sum  = {1'b0, r_ptr} + {1'b0, w_level};
  assign w_ptr_next = (w_ptr_sum >= 5'(N_ELEM)) ? 4'(w_ptr_sum - 5'(N_ELEM)) : w_ptr_sum[3:0];
  assign o_ptr_out  = r_ptr;
`else
  assign w_elem    = w_therm;
  assign o_ptr_out = 4'd0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_elem  <= '0;
      r_valid <= 1'b0;
      r_level <= 4'd0;
`ifdef DWA_ROTATE_EN
      r_ptr   <= 4'd0;
`endif
    end else begin
      r_valid <= i_in_valid;
      if (i_in_valid) begin
        r_elem  <= w_elem;
        r_level <= w_level;
`ifdef DWA_ROTATE_EN
        r_ptr   <= w_ptr_next;
`endif
      end
    end
  end

  assign o_elem_out  = r_elem;
  assign o_valid_out = r_valid;

  a_popcount: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ($countones(o_elem_out) == int'(r_level)));

  a_ptr_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_ptr_out < 4'(N_ELEM)));

endmodule

// File: tb/tb_dwa_thermometer_driver.sv
// Directed and model-checked bench for dwa_thermometer_driver; expectations follow DWA_ROTATE_EN.
module tb_dwa_thermometer_driver;

  logic        clk;
  logic        rst_n;
  logic [3:0]  codeIn;
  logic        inValid;
  logic        mute;
  logic [13:0] elemOut;
  logic        validOut;
  logic [3:0]  ptrOut;

  int checks;
  int errors;

  dwa_thermometer_driver dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_code_in   (codeIn),
    .i_in_valid  (inValid),
    .i_mute      (mute),
    .o_elem_out  (elemOut),
    .o_valid_out (validOut),
    .o_ptr_out   (ptrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the accepting rising edge.
  task automatic applyStimulus(input logic [3:0] c, input logic v, input logic m);
    @(negedge clk);
    codeIn  = c;
    inValid = v;
    mute    = m;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    inValid = 1'b0;
    mute    = 1'b0;
    codeIn  = 4'd0;
    rst_n   = 1'b0;
    #2;
    rst_n   = 1'b1;
  endtask

  function automatic int levelOf(input logic [3:0] c, input logic m);
    if (m) return 7;
    if (c[3]) return 7 - int'(c[2:0]);
    return 7 + int'(c[2:0]);
  endfunction

  // Independent reference: set L bits one by one starting from the pointer.
  function automatic logic [13:0] elemOf(input int p, input int lvl);
    logic [13:0] e;
    e = '0;
    for (int i = 0; i < lvl; i++) e[(p + i) % 14] = 1'b1;
    return e;
  endfunction

  // Expected pointer after an accept, or 0 in static mode.
  function automatic int nextPtr(input int p, input int lvl);
`ifdef DWA_ROTATE_EN
    return (p + lvl) % 14;
`else
    return 0 * (p + lvl);
`endif
  endfunction

  initial begin
    int modelPtr;
    int lvl;
    logic [13:0] modelElem;
    logic [3:0] rc;
    logic rv;
    logic rm;

    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    codeIn   = 4'd0;
    inValid  = 1'b0;
    mute     = 1'b0;

    #12;
    checkOutput("reset_elem", elemOut, 14'h0000);
    checkOutput("reset_valid", 14'(validOut), 14'd0);
    checkOutput("reset_ptr", 14'(ptrOut), 14'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Case 2: L=10 then L=4
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("c2_elem1", elemOut, 14'h03FF);
    checkOutput("c2_valid1", 14'(validOut), 14'd1);
`ifdef DWA_ROTATE_EN
    checkOutput("c2_ptr1", 14'(ptrOut), 14'd10);
    applyStimulus(4'b1011, 1'b1, 1'b0);
    checkOutput("c2_elem2", elemOut, 14'h3C00);
`else
    checkOutput("c2_ptr1", 14'(ptrOut), 14'd0);
    applyStimulus(4'b1011, 1'b1, 1'b0);
    checkOutput("c2_elem2", elemOut, 14'h000F);
`endif
    checkOutput("c2_ptr2", 14'(ptrOut), 14'd0);

    // Case 3: wrap-around from ptr 10 with L=7
    doReset();
    applyStimulus(4'b0011, 1'b1, 1'b0);
    checkOutput("c3_elem1", elemOut, 14'h03FF);
    applyStimulus(4'b0000, 1'b1, 1'b0);
`ifdef DWA_ROTATE_EN
    checkOutput("c3_elem2", elemOut, 14'h3C07);
    checkOutput("c3_ptr2", 14'(ptrOut), 14'd3);
`else
    checkOutput("c3_elem2", elemOut, 14'h007F);
    checkOutput("c3_ptr2", 14'(ptrOut), 14'd0);
`endif

    // Case 5: idle hold, then L=0
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0101, 1'b0, 1'b0);
      checkOutput("c5_idle_valid", 14'(validOut), 14'd0);
`ifdef DWA_ROTATE_EN
      checkOutput("c5_idle_elem", elemOut, 14'h3C07);
      checkOutput("c5_idle_ptr", 14'(ptrOut), 14'd3);
`else
      checkOutput("c5_idle_elem", elemOut, 14'h007F);
      checkOutput("c5_idle_ptr", 14'(ptrOut), 14'd0);
`endif
    end
    applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("c5_l0_elem", elemOut, 14'h0000);
    checkOutput("c5_l0_valid", 14'(validOut), 14'd1);
`ifdef DWA_ROTATE_EN
    checkOutput("c5_l0_ptr", 14'(ptrOut), 14'd3);
`else
    checkOutput("c5_l0_ptr", 14'(ptrOut), 14'd0);
`endif

    // Case 4: negative zero, then mute overriding full-scale code
    doReset();
    applyStimulus(4'b1000, 1'b1, 1'b0);
    checkOutput("c4_negzero_elem", elemOut, 14'h007F);
`ifdef DWA_ROTATE_EN
    checkOutput("c4_negzero_ptr", 14'(ptrOut), 14'd7);
    applyStimulus(4'b0111, 1'b1, 1'b1);
    checkOutput("c4_mute_elem", elemOut, 14'h3F80);
`else
    checkOutput("c4_negzero_ptr", 14'(ptrOut), 14'd0);
    applyStimulus(4'b0111, 1'b1, 1'b1);
    checkOutput("c4_mute_elem", elemOut, 14'h007F);
`endif
    checkOutput("c4_mute_ptr", 14'(ptrOut), 14'd0);

    // Case 1: asynchronous reset mid-stream, then L=14
    applyStimulus(4'b0011, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("c1_async_elem", elemOut, 14'h0000);
    checkOutput("c1_async_valid", 14'(validOut), 14'd0);
    checkOutput("c1_async_ptr", 14'(ptrOut), 14'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    codeIn  = 4'b0111;
    inValid = 1'b1;
    mute    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("c1_full_elem", elemOut, 14'h3FFF);
    checkOutput("c1_full_ptr", 14'(ptrOut), 14'd0);
    checkOutput("c1_full_valid", 14'(validOut), 14'd1);

    // Randomised run against the reference model, including idle and mute cycles
    doReset();
    modelPtr  = 0;
    modelElem = '0;
    for (int n = 0; n < 400; n++) begin
      rc = 4'($urandom_range(0, 15));
      rv = ($urandom_range(0, 3) != 0);
      rm = ($urandom_range(0, 7) == 0);
      applyStimulus(rc, rv, rm);
      if (rv) begin
        lvl       = levelOf(rc, rm);
        modelElem = elemOf(modelPtr, lvl);
        modelPtr  = nextPtr(modelPtr, lvl);
        checkOutput("rnd_popcount", 14'($countones(elemOut)), 14'(lvl));
      end
      checkOutput("rnd_elem", elemOut, modelElem);
      checkOutput("rnd_ptr", 14'(ptrOut), 14'(modelPtr));
      checkOutput("rnd_valid", 14'(validOut), 14'(rv));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dwa_thermometer_driver.md
Name: dwa_thermometer_driver

Overview:
Consumes the 4-bit sign-magnitude code from the delta-sigma modulator and converts it to a 14-element unit-element DAC drive word. Uses data-weighted averaging (DWA): a rotating pointer spreads element mismatch into high-frequency noise. Sits directly downstream of the modulator, between it and the unit-element DAC pads. Registered output, one code per in_valid cycle.

Parameters:
CODE_W, 4, input code width (1 sign bit + CODE_W-1 magnitude bits); only 4 is supported
N_ELEM, 14, unit elements = 2*(2^(CODE_W-1)-1); a localparam derived from CODE_W, not overridable
MID_LEVEL, 7, level used for mute and for zero codes; a localparam = N_ELEM/2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
code_in  input  4  modulator output; bit 3 = sign (1 = negative), bits 2:0 = magnitude
in_valid  input  1  code_in valid this cycle
mute  input  1  forces mid-scale level regardless of code_in
elem_out  output  14  unit-element enables; bit i drives element i
valid_out  output  1  elem_out updated this cycle
ptr_out  output  4  current DWA pointer (0..13), for debug/verification

Behaviour:
- Reset: reset low asynchronously clears elem_out=0, valid_out=0, ptr_out=0. This applies at any time, including mid-stream. The first accepted code after release starts at ptr 0.
- Level mapping (combinational, from code_in):
  - sign=0: L = 7 + mag
  - sign=1: L = 7 - mag
  - Range is L = 0..14.
  - Negative zero (4'b1000) maps to L=7, identical to 4'b0000.
- Mute: if mute=1 and in_valid=1, L = 7. mute overrides code_in.
- Accept: on a rising clk with in_valid=1, register elem_out with exactly L bits set. The set bits are the indices ptr, ptr+1, ..., ptr+L-1, taken modulo 14.
- Pointer update in the same cycle: ptr <= (ptr + L) mod 14. ptr+L is at most 27; reduce it with a single conditional subtract of 14.
- Latency: 1 cycle. The code sampled at edge k appears on elem_out after edge k, and valid_out=1 for that one cycle.
- Idle: if in_valid=0, elem_out holds its previous value, ptr is unchanged, and valid_out=0.
- Boundary cases:
  - L=0: elem_out=0 and ptr is unchanged.
  - L=14: elem_out=14'h3FFF and ptr is unchanged.
  - Wrap-around selects both the high and the low indices, with no gap.
- Invariants, checked by assertion:
  - popcount(elem_out) equals the registered L.
  - ptr_out is always in 0..13; values 14 and 15 are unreachable.
- No back-pressure: the block accepts a code every cycle, matching the modulator rate.

Optional Feature:
Macro DWA_ROTATE_EN.
- Defined: DWA rotation exactly as described in Behaviour.
- Undefined: static thermometer encoding. elem_out sets bits 0..L-1, ptr_out stays 0, and the pointer adder is removed. Level mapping, mute, handshake and latency are unchanged.

Test Plan:
1. Assert reset low mid-stream with in_valid=1 and code 4'b0011 -> immediately elem_out=14'h0000, valid_out=0, ptr_out=0. After release, code 4'b0111 (L=14) -> elem_out=14'h3FFF, ptr_out=0.
2. From reset, code 4'b0011 (L=10) -> elem_out=14'h03FF, ptr_out=10. Next code 4'b1011 (L=4) -> elem_out=14'h3C00, ptr_out=0.
3. Wrap: from reset, code 4'b0011 (ptr becomes 10), then 4'b0000 (L=7) -> elem_out=14'h3C07, ptr_out=3.
4. Negative zero and mute: from reset, code 4'b1000 -> elem_out=14'h007F, ptr_out=7. Then code 4'b0111 with mute=1 -> elem_out=14'h3F80, ptr_out=0.
5. Idle hold: after case 3, drop in_valid for 5 cycles -> elem_out stays 14'h3C07, ptr_out stays 3, valid_out=0. Then code 4'b1111 (L=0) -> elem_out=14'h0000, ptr_out=3.
6. DWA_ROTATE_EN undefined: repeat case 3 -> elem_out=14'h03FF then 14'h007F, with ptr_out=0 throughout. Random 10k codes -> popcount(elem_out)=L every valid cycle.
